// File: rtl/time_ctrl_pkg.sv
// Shared types, field limits and time-word packing for the current-time
// set controller.
package time_ctrl_pkg;

    // Time word layout shared by CTO (from the counter chain) and CTI (to it)
    localparam int CT_W      = 15;
    localparam int MONES_LSB = 0;
    localparam int MONES_W   = 4;
    localparam int MTENS_LSB = 4;
    localparam int MTENS_W   = 3;
    localparam int HOUR_LSB  = 7;
    localparam int HOUR_W    = 5;
    localparam int DAY_LSB   = 12;
    localparam int DAY_W     = 3;

    // Largest legal value of each field; anything at or above wraps to 0
    localparam logic [DAY_W-1:0]   DAY_MAX   = 3'd6;
    localparam logic [HOUR_W-1:0]  HOUR_MAX  = 5'd23;
    localparam logic [MTENS_W-1:0] MTENS_MAX = 3'd5;
    localparam logic [MONES_W-1:0] MONES_MAX = 4'd9;

    // Field_Sel codes presented to the display blink logic
    localparam logic [1:0] FS_DAY   = 2'd0;
    localparam logic [1:0] FS_HOUR  = 2'd1;
    localparam logic [1:0] FS_MTENS = 2'd2;
    localparam logic [1:0] FS_MONES = 2'd3;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SET_DAY   = 3'd1,
        ST_SET_HOUR  = 3'd2,
        ST_SET_MTENS = 3'd3,
        ST_SET_MONES = 3'd4,
        ST_LOAD      = 3'd5
    } state_t;

    // Shadow copy of the time being edited
    typedef struct packed {
        logic [DAY_W-1:0]   day;
        logic [HOUR_W-1:0]  hour;
        logic [MTENS_W-1:0] mtens;
        logic [MONES_W-1:0] mones;
    } time_fields_t;

    function automatic time_fields_t unpack_time(input logic [CT_W-1:0] w);
        time_fields_t f;
        f.day   = w[DAY_LSB   +: DAY_W];
        f.hour  = w[HOUR_LSB  +: HOUR_W];
        f.mtens = w[MTENS_LSB +: MTENS_W];
        f.mones = w[MONES_LSB +: MONES_W];
        return f;
    endfunction

    function automatic logic [CT_W-1:0] pack_time(input time_fields_t f);
        logic [CT_W-1:0] w;
        w = '0;
        w[DAY_LSB   +: DAY_W]   = f.day;
        w[HOUR_LSB  +: HOUR_W]  = f.hour;
        w[MTENS_LSB +: MTENS_W] = f.mtens;
        w[MONES_LSB +: MONES_W] = f.mones;
        return w;
    endfunction

    // Field_Sel code for a SET state (0 for anything else)
    function automatic logic [1:0] field_index(input state_t s);
        case (s)
            ST_SET_HOUR:  return FS_HOUR;
            ST_SET_MTENS: return FS_MTENS;
            ST_SET_MONES: return FS_MONES;
            default:      return FS_DAY;
        endcase
    endfunction

    // Where a Mode press takes each SET state; the last field commits
    function automatic state_t next_field(input state_t s);
        case (s)
            ST_SET_DAY:   return ST_SET_HOUR;
            ST_SET_HOUR:  return ST_SET_MTENS;
            ST_SET_MTENS: return ST_SET_MONES;
            default:      return ST_LOAD;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for one debounced button level. A held button
// yields a single one-cycle pulse.
module btn_edge_detect (
    input  logic Clk,
    input  logic Clr_n,
    input  logic btn,
    output logic btn_edge
);

    logic prev;

    // Remember last cycle's level so a rise can be seen
    always_ff @(posedge Clk) begin
        if (!Clr_n) prev <= 1'b0;
        else        prev <= btn;
    end

    assign btn_edge = btn & ~prev;

endmodule

// File: rtl/time_set_controller.sv
// Mode/set sequencer for the current-time counter chain. Runs the chain in
// normal operation, freezes it and edits a shadow copy field by field on
// user request, then commits the edit with a one-cycle parallel load.
module time_set_controller
    import time_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 30000,
    parameter int TO_W           = 15
) (
    input  logic            Clk,
    input  logic            Clr_n,
    input  logic            Mode_Btn,
    input  logic            Inc_Btn,
    input  logic            Cancel_Btn,
    input  logic [CT_W-1:0] CTO,
    output logic [CT_W-1:0] CTI,
    output logic            LD_CT,
    output logic            Clr_CT,
    output logic            EN_CT,
    output logic            Set_Mode,
    output logic [1:0]      Field_Sel
);

    // Counter value on the last idle cycle before auto-cancel
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic         mode_edge;
    logic         inc_edge;
    logic         cancel_edge;
    logic         any_edge;
    logic         in_set;
    logic         timeout_hit;
    state_t       state;
    state_t       state_adv;
    time_fields_t shadow;
    time_fields_t shadow_nxt;
    logic [TO_W-1:0] to_cnt;

    btn_edge_detect u_mode_edge (
        .Clk      (Clk),
        .Clr_n    (Clr_n),
        .btn      (Mode_Btn),
        .btn_edge (mode_edge)
    );

    btn_edge_detect u_inc_edge (
        .Clk      (Clk),
        .Clr_n    (Clr_n),
        .btn      (Inc_Btn),
        .btn_edge (inc_edge)
    );

    btn_edge_detect u_cancel_edge (
        .Clk      (Clk),
        .Clr_n    (Clr_n),
        .btn      (Cancel_Btn),
        .btn_edge (cancel_edge)
    );

    assign any_edge  = mode_edge | inc_edge | cancel_edge;
    assign in_set    = (state == ST_SET_DAY)   || (state == ST_SET_HOUR) ||
                       (state == ST_SET_MTENS) || (state == ST_SET_MONES);
    // Any button activity restarts the idle window, so it also beats timeout
    assign timeout_hit = in_set && !any_edge && (to_cnt == TO_LAST);
    assign state_adv   = next_field(state);

    // Shadow after this cycle's Inc: wrap-increment only the field being edited
    always_comb begin
        shadow_nxt = shadow;
        if (inc_edge) begin
            case (state)
                ST_SET_DAY:
                    shadow_nxt.day   = (shadow.day   >= DAY_MAX)   ? '0 : shadow.day   + 3'd1;
                ST_SET_HOUR:
                    shadow_nxt.hour  = (shadow.hour  >= HOUR_MAX)  ? '0 : shadow.hour  + 5'd1;
                ST_SET_MTENS:
                    shadow_nxt.mtens = (shadow.mtens >= MTENS_MAX) ? '0 : shadow.mtens + 3'd1;
                ST_SET_MONES:
                    shadow_nxt.mones = (shadow.mones >= MONES_MAX) ? '0 : shadow.mones + 4'd1;
                default: ;
            endcase
        end
    end

    // Sequencer with all outputs registered alongside the state
    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            state     <= ST_RUN;
            shadow    <= '0;
            to_cnt    <= '0;
            CTI       <= '0;
            LD_CT     <= 1'b0;
            Clr_CT    <= 1'b1;
            EN_CT     <= 1'b0;
            Set_Mode  <= 1'b0;
            Field_Sel <= FS_DAY;
        end else begin
            Clr_CT <= 1'b0;
            LD_CT  <= 1'b0;
            case (state)
                ST_RUN: begin
                    EN_CT     <= 1'b1;
                    Set_Mode  <= 1'b0;
                    Field_Sel <= FS_DAY;
                    // Inc and Cancel mean nothing while running
                    if (mode_edge) begin
                        shadow    <= unpack_time(CTO);
                        to_cnt    <= '0;
                        EN_CT     <= 1'b0;
                        Set_Mode  <= 1'b1;
                        Field_Sel <= FS_DAY;
                        state     <= ST_SET_DAY;
                    end
                end

                ST_SET_DAY, ST_SET_HOUR, ST_SET_MTENS, ST_SET_MONES: begin
                    if (cancel_edge || timeout_hit) begin
                        // Abandon the edit; shadow is simply overwritten next time
                        state     <= ST_RUN;
                        EN_CT     <= 1'b1;
                        Set_Mode  <= 1'b0;
                        Field_Sel <= FS_DAY;
                        to_cnt    <= '0;
                    end else begin
                        to_cnt <= any_edge ? '0 : to_cnt + TO_W'(1);
                        shadow <= shadow_nxt;
                        if (mode_edge) begin
                            state <= state_adv;
                            if (state_adv == ST_LOAD) begin
                                // Commit includes an Inc that lands on the same edge
                                CTI       <= pack_time(shadow_nxt);
                                LD_CT     <= 1'b1;
                                Set_Mode  <= 1'b0;
                                Field_Sel <= FS_DAY;
                            end else begin
                                Field_Sel <= field_index(state_adv);
                            end
                        end
                    end
                end

                ST_LOAD: begin
                    // Single load cycle; CTI keeps the committed value afterwards
                    state  <= ST_RUN;
                    EN_CT  <= 1'b1;
                    to_cnt <= '0;
                end

                default: begin
                    state     <= ST_RUN;
                    EN_CT     <= 1'b1;
                    Set_Mode  <= 1'b0;
                    Field_Sel <= FS_DAY;
                    to_cnt    <= '0;
                end
            endcase
        end
    end

endmodule
